nn_dma_rd_arb: RTL and testbench
================================

NN_DMA_RD_ARB -- requirements
Module: nn_dma_rd_arb

Interface
REQ-001 SHALL have parameter DMA_ADDR_WIDTH, default 6: DMA word address width.
REQ-002 SHALL have parameter LEN_WIDTH, default 7: burst length field width, in 16-bit words.
REQ-003 SHALL have parameter RD_LAT, default 1, legal 1..4: DMA read latency, from o_dma_rd_en to valid i_dma_rd_data.
REQ-004 SHALL have port i_clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port i_req, input, 2: burst request; bit 0 = image-buffer fill, bit 1 = weight-memory fill; level, held until granted.
REQ-007 SHALL have ports i_base0 / i_base1, input, DMA_ADDR_WIDTH: burst start address per requester.
REQ-008 SHALL have ports i_len0 / i_len1, input, LEN_WIDTH: burst word count per requester.
REQ-009 SHALL have port o_gnt, output, 2: one-hot, one-cycle pulse that acknowledges the burst.
REQ-010 SHALL have port o_dma_rd_en, output, 1: DMA read strobe.
REQ-011 SHALL have port o_dma_rd_addr, output, DMA_ADDR_WIDTH: DMA read address.
REQ-012 SHALL have port i_dma_rd_data, input, 16: DMA read data.
REQ-013 SHALL have port o_rd_valid, output, 2: one-hot; marks a returned word for the owning requester.
REQ-014 SHALL have port o_rd_data, output, 16: returned word, equal to i_dma_rd_data.
REQ-015 SHALL have port o_done, output, 2: one-hot, one-cycle pulse at burst completion.
REQ-016 SHALL have port o_busy, output, 1: high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, BURST, DRAIN, ZLEN.
REQ-018 In IDLE, at the edge where i_req is nonzero, SHALL select requester k, latch i_base_k and i_len_k, and enter BURST (len>0) or ZLEN (len=0).
REQ-019 Arbitration SHALL be round-robin: single request wins; on simultaneous requests, the requester not granted last wins; after reset, requester 0 has priority.
REQ-020 o_gnt[k] SHALL pulse in the first cycle after the selecting edge (cycle N+1).
REQ-021 In BURST cycles N+1..N+len, o_dma_rd_en SHALL be 1 and o_dma_rd_addr SHALL be base+i, i=0..len-1.
REQ-022 Address increment SHALL wrap modulo 2^DMA_ADDR_WIDTH.
REQ-023 o_rd_valid[k] SHALL assert exactly RD_LAT cycles after each o_dma_rd_en cycle, via a valid shift register tagged with the owner.
REQ-024 After the last read, the FSM SHALL enter DRAIN for RD_LAT cycles; o_done[k] SHALL pulse in the cycle carrying the last o_rd_valid[k]; the next cycle SHALL be IDLE.
REQ-025 ZLEN SHALL last one cycle, with o_gnt[k] and o_done[k] both pulsing and no DMA read; the FSM then SHALL return to IDLE.
REQ-026 Requests SHALL NOT be sampled outside IDLE; at least one IDLE cycle SHALL separate bursts.
REQ-027 Changes to i_req, i_base or i_len after grant SHALL NOT affect the running burst.
REQ-028 When neither o_rd_valid bit is high, o_rd_data SHALL still follow i_dma_rd_data, and consumers SHALL ignore it.

Reset
REQ-029 With i_rst high at an edge, the block SHALL enter IDLE and clear o_gnt, o_dma_rd_en, o_dma_rd_addr, o_rd_valid, o_done, o_busy, the valid pipeline and the round-robin pointer (requester 0 next).
REQ-030 Reset mid-burst SHALL abort the burst with no o_done; in-flight data SHALL be discarded with no o_rd_valid.

Structure
REQ-031 Package nn_pkg SHALL hold the FSM state encoding and requester index constants (REQ_IMG=0, REQ_WGT=1).
REQ-032 The 2-way round-robin select SHALL be a sub-module nn_rr_arb2 containing the pointer, with inputs req and update.

Verification
REQ-033 Single burst: i_req=01, base0=5, len0=3 -> gnt=01 at N+1; addr 5,6,7 at N+1..N+3; rd_valid[0] at N+2..N+4; done[0] at N+4.
REQ-034 Simultaneous requests: i_req=11 after reset -> requester 0 first, then requester 1; repeat with i_req held at 11 -> alternation 0,1,0,1.
REQ-035 Address wrap: base1=62, len1=4, DMA_ADDR_WIDTH=6 -> addresses 62,63,0,1; done[1] after 4 rd_valid[1].
REQ-036 Zero length: len0=0 -> gnt[0] and done[0] in the same cycle, o_dma_rd_en never high, back to IDLE.
REQ-037 Reset mid-burst: i_rst at 2nd read of len=8 -> next cycle IDLE, all outputs 0, no done; a fresh i_req=10 is then granted normally.
REQ-038 RD_LAT=3 build: len=2 -> rd_valid 3 cycles after each rd_en; done coincides with the 2nd rd_valid.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and constants for the NN DMA read arbiter.
package nn_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBurst = 2'd1,
    StDrain = 2'd2,
    StZlen  = 2'd3
  } nn_state_e;

  localparam int unsigned REQ_IMG = 0;
  localparam int unsigned REQ_WGT = 1;

  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/nn_rr_arb2.sv
// Two-way round-robin select; the pointer names the requester that wins a tie.
module nn_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);
  import nn_pkg::*;

  logic prio_q;

  always_comb begin
    gnt = '0;
    if (req[REQ_IMG] && (!req[REQ_WGT] || !prio_q)) begin
      gnt[REQ_IMG] = 1'b1;
    end else if (req[REQ_WGT]) begin
      gnt[REQ_WGT] = 1'b1;
    end
  end

  // After granting the image side, the weight side gets the next tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prio_q <= 1'b0;
    end else if (update && (|gnt)) begin
      prio_q <= gnt[REQ_IMG];
    end
  end

endmodule

// File: rtl/nn_dma_rd_arb.sv
// Arbitrates image/weight burst requests onto one DMA read port and routes returned words.
module nn_dma_rd_arb #(
  parameter int unsigned DMA_ADDR_WIDTH = 6,
  parameter int unsigned LEN_WIDTH      = 7,
  parameter int unsigned RD_LAT         = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [1:0]                i_req,
  input  logic [DMA_ADDR_WIDTH-1:0] i_base0,
  input  logic [DMA_ADDR_WIDTH-1:0] i_base1,
  input  logic [LEN_WIDTH-1:0]      i_len0,
  input  logic [LEN_WIDTH-1:0]      i_len1,
  output logic [1:0]                o_gnt,
  output logic                      o_dma_rd_en,
  output logic [DMA_ADDR_WIDTH-1:0] o_dma_rd_addr,
  input  logic [15:0]               i_dma_rd_data,
  output logic [1:0]                o_rd_valid,
  output logic [15:0]               o_rd_data,
  output logic [1:0]                o_done,
  output logic                      o_busy
);
  import nn_pkg::*;

  localparam logic [DMA_ADDR_WIDTH-1:0] AddrOne   = 1;
  localparam logic [LEN_WIDTH-1:0]      LenOne    = 1;
  localparam logic [1:0]                DrainInit = 2'(RD_LAT - 1);

  nn_state_e                 state_q;
  logic                      owner_q;
  logic [1:0]                gnt_q;
  logic [1:0]                done_q;
  logic                      rd_en_q;
  logic [DMA_ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]      rem_q;
  logic [1:0]                drain_q;
  logic [RD_LAT-1:0]         vld_q;
  logic [RD_LAT-1:0]         own_q;

  logic [1:0]                arb_gnt;
  logic [DMA_ADDR_WIDTH-1:0] sel_base;
  logic [LEN_WIDTH-1:0]      sel_len;

  nn_rr_arb2 u_arb (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .req    (i_req),
    .update (state_q == StIdle),
    .gnt    (arb_gnt)
  );

  assign sel_base = arb_gnt[REQ_WGT] ? i_base1 : i_base0;
  assign sel_len  = arb_gnt[REQ_WGT] ? i_len1  : i_len0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      drain_q <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (|i_req) begin
            owner_q <= arb_gnt[REQ_WGT];
            gnt_q   <= arb_gnt;
            if (sel_len == '0) begin
              state_q <= StZlen;
              done_q  <= arb_gnt;
            end else begin
              state_q <= StBurst;
              rd_en_q <= 1'b1;
              addr_q  <= sel_base;
              rem_q   <= sel_len - LenOne;
            end
          end
        end
        StBurst: begin
          if (rem_q == '0) begin
            state_q <= StDrain;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            drain_q <= DrainInit;
            // Done lands in the last drain cycle, alongside the final returned word.
            if (DrainInit == 2'd0) begin
              done_q <= req_onehot(owner_q);
            end
          end else begin
            addr_q <= addr_q + AddrOne;
            rem_q  <= rem_q - LenOne;
          end
        end
        StDrain: begin
          if (drain_q == 2'd0) begin
            state_q <= StIdle;
          end else begin
            drain_q <= drain_q - 2'd1;
            if (drain_q == 2'd1) begin
              done_q <= req_onehot(owner_q);
            end
          end
        end
        StZlen: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Owner-tagged valid pipeline matching the DMA read latency.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q[0] <= rd_en_q;
      own_q[0] <= owner_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
    end
  end

  always_comb begin
    o_rd_valid = '0;
    if (vld_q[RD_LAT-1]) begin
      o_rd_valid = req_onehot(own_q[RD_LAT-1]);
    end
  end

  assign o_gnt         = gnt_q;
  assign o_done        = done_q;
  assign o_dma_rd_en   = rd_en_q;
  assign o_dma_rd_addr = addr_q;
  assign o_rd_data     = i_dma_rd_data;
  assign o_busy        = (state_q != StIdle);

endmodule

// File: tb/tb_nn_dma_rd_arb.sv
// Self-checking bench for nn_dma_rd_arb: RD_LAT=1 and RD_LAT=3 instances with a memory model.
module tb_nn_dma_rd_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [5:0] base0, base1;
  logic [6:0] len0, len1;
  logic       sel;

  logic [1:0] req_a, req_b;
  assign req_a = sel ? 2'b00 : req;
  assign req_b = sel ? req : 2'b00;

  logic [1:0]  gnt_a, rd_valid_a, done_a, gnt_b, rd_valid_b, done_b;
  logic        rd_en_a, busy_a, rd_en_b, busy_b;
  logic [5:0]  addr_a, addr_b;
  logic [15:0] rd_data_a, rd_data_b, dma_data_a, dma_data_b;

  logic [1:0]  obs_gnt, obs_vld, obs_done;
  logic        obs_en, obs_busy;
  logic [5:0]  obs_addr;
  logic [15:0] obs_rd_data, obs_dma_data;

  assign obs_gnt      = sel ? gnt_b : gnt_a;
  assign obs_vld      = sel ? rd_valid_b : rd_valid_a;
  assign obs_done     = sel ? done_b : done_a;
  assign obs_en       = sel ? rd_en_b : rd_en_a;
  assign obs_busy     = sel ? busy_b : busy_a;
  assign obs_addr     = sel ? addr_b : addr_a;
  assign obs_rd_data  = sel ? rd_data_b : rd_data_a;
  assign obs_dma_data = sel ? dma_data_b : dma_data_a;

  int vectors = 0;
  int errs    = 0;

  logic [5:0]  exp_addr[$];
  logic [16:0] exp_data[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [5:0] a);
    return 16'hC300 ^ {a, 2'b01, a, 2'b10};
  endfunction

  // Memory model: word for a read strobe appears RD_LAT cycles later.
  logic [15:0] pipe_a;
  logic [15:0] pipe_b[3];
  always @(posedge clk) begin
    pipe_a    <= rd_en_a ? mem_word(addr_a) : 16'h0BAD;
    pipe_b[0] <= rd_en_b ? mem_word(addr_b) : 16'h0BAD;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign dma_data_a = pipe_a;
  assign dma_data_b = pipe_b[2];

  nn_dma_rd_arb #(.DMA_ADDR_WIDTH(6), .LEN_WIDTH(7), .RD_LAT(1)) u_dut_a (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req_a),
    .i_base0       (base0),
    .i_base1       (base1),
    .i_len0        (len0),
    .i_len1        (len1),
    .o_gnt         (gnt_a),
    .o_dma_rd_en   (rd_en_a),
    .o_dma_rd_addr (addr_a),
    .i_dma_rd_data (dma_data_a),
    .o_rd_valid    (rd_valid_a),
    .o_rd_data     (rd_data_a),
    .o_done        (done_a),
    .o_busy        (busy_a)
  );

  nn_dma_rd_arb #(.DMA_ADDR_WIDTH(6), .LEN_WIDTH(7), .RD_LAT(3)) u_dut_b (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req_b),
    .i_base0       (base0),
    .i_base1       (base1),
    .i_len0        (len0),
    .i_len1        (len1),
    .o_gnt         (gnt_b),
    .o_dma_rd_en   (rd_en_b),
    .o_dma_rd_addr (addr_b),
    .i_dma_rd_data (dma_data_b),
    .o_rd_valid    (rd_valid_b),
    .o_rd_data     (rd_data_b),
    .o_done        (done_b),
    .o_busy        (busy_b)
  );

  // Caller has set req/base/len; the next rising edge is the selecting edge.
  task automatic run_burst(input int k, input bit hold, input bit scramble);
    int         len, base, lat, total;
    logic [1:0] oh, e_gnt, e_vld, e_done;
    logic       e_en, e_busy;
    logic [5:0] a;
    logic [16:0] d;
    lat  = sel ? 3 : 1;
    base = (k == 1) ? int'(base1) : int'(base0);
    len  = (k == 1) ? int'(len1) : int'(len0);
    oh   = (k == 1) ? 2'b10 : 2'b01;
    for (int i = 0; i < len; i++) begin
      a = 6'((base + i) % 64);
      exp_addr.push_back(a);
      exp_data.push_back({k[0], mem_word(a)});
    end
    total = (len == 0) ? 1 : len + lat;
    @(posedge clk);
    #1;
    if (!hold) req = 2'b00;
    if (scramble) begin
      base0 = 6'($urandom);
      base1 = 6'($urandom);
      len0  = 7'($urandom_range(0, 127));
      len1  = 7'($urandom_range(0, 127));
    end
    for (int t = 1; t <= total + 1; t++) begin
      @(negedge clk);
      e_gnt  = (t == 1) ? oh : 2'b00;
      e_en   = (len > 0) && (t <= len);
      e_vld  = ((len > 0) && (t > lat) && (t <= len + lat)) ? oh : 2'b00;
      e_done = (t == total) ? oh : 2'b00;
      e_busy = (t <= total);
      vectors += 6;
      if (obs_gnt !== e_gnt) begin
        $display("FAIL gnt t=%0d got %b want %b", t, obs_gnt, e_gnt); errs++;
      end
      if (obs_en !== e_en) begin
        $display("FAIL rd_en t=%0d got %b want %b", t, obs_en, e_en); errs++;
      end
      if (obs_vld !== e_vld) begin
        $display("FAIL rd_valid t=%0d got %b want %b", t, obs_vld, e_vld); errs++;
      end
      if (obs_done !== e_done) begin
        $display("FAIL done t=%0d got %b want %b", t, obs_done, e_done); errs++;
      end
      if (obs_busy !== e_busy) begin
        $display("FAIL busy t=%0d got %b want %b", t, obs_busy, e_busy); errs++;
      end
      if (obs_rd_data !== obs_dma_data) begin
        $display("FAIL rd_data_follow t=%0d got %h want %h", t, obs_rd_data, obs_dma_data);
        errs++;
      end
      if (obs_en === 1'b1) begin
        vectors++;
        if (exp_addr.size() == 0) begin
          $display("FAIL addr_extra t=%0d got %0d want none", t, obs_addr); errs++;
        end else begin
          a = exp_addr.pop_front();
          if (obs_addr !== a) begin
            $display("FAIL addr t=%0d got %0d want %0d", t, obs_addr, a); errs++;
          end
        end
      end
      if (obs_vld !== 2'b00) begin
        vectors++;
        if (exp_data.size() == 0) begin
          $display("FAIL data_extra t=%0d got %h want none", t, obs_rd_data); errs++;
        end else begin
          d = exp_data.pop_front();
          if ({obs_vld[1], obs_rd_data} !== d) begin
            $display("FAIL data t=%0d got %h want %h", t, {obs_vld[1], obs_rd_data}, d);
            errs++;
          end
        end
      end
    end
    vectors++;
    if (exp_addr.size() != 0 || exp_data.size() != 0) begin
      $display("FAIL drain_queues got %0d/%0d left want 0/0", exp_addr.size(), exp_data.size());
      errs++;
    end
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 2;
    if ({gnt_a, rd_en_a, addr_a, rd_valid_a, done_a, busy_a} !== 14'd0) begin
      $display("FAIL reset_a got %h want 0", {gnt_a, rd_en_a, addr_a, rd_valid_a, done_a, busy_a});
      errs++;
    end
    if ({gnt_b, rd_en_b, addr_b, rd_valid_b, done_b, busy_b} !== 14'd0) begin
      $display("FAIL reset_b got %h want 0", {gnt_b, rd_en_b, addr_b, rd_valid_b, done_b, busy_b});
      errs++;
    end
  endtask

  task automatic test_single();
    base0 = 6'd5; len0 = 7'd3; req = 2'b01;
    run_burst(0, 1'b0, 1'b0);
  endtask

  task automatic test_round_robin();
    do_reset();
    base0 = 6'd10; len0 = 7'd2; base1 = 6'd20; len1 = 7'd3;
    req = 2'b11;
    run_burst(0, 1'b1, 1'b0);
    run_burst(1, 1'b1, 1'b0);
    run_burst(0, 1'b1, 1'b0);
    run_burst(1, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    base1 = 6'd62; len1 = 7'd4; req = 2'b10;
    run_burst(1, 1'b0, 1'b0);
  endtask

  task automatic test_zlen();
    len0 = 7'd0; req = 2'b01;
    run_burst(0, 1'b0, 1'b0);
  endtask

  task automatic test_stable_inputs();
    base0 = 6'd30; len0 = 7'd5; req = 2'b01;
    run_burst(0, 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    base0 = 6'd12; len0 = 7'd8; req = 2'b01;
    @(posedge clk);
    #1 req = 2'b00;
    @(negedge clk);
    vectors++;
    if ({rd_en_a, addr_a} !== {1'b1, 6'd12}) begin
      $display("FAIL midrst_rd1 got %b/%0d want 1/12", rd_en_a, addr_a); errs++;
    end
    @(negedge clk);
    vectors++;
    if ({rd_en_a, addr_a} !== {1'b1, 6'd13}) begin
      $display("FAIL midrst_rd2 got %b/%0d want 1/13", rd_en_a, addr_a); errs++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if ({gnt_a, rd_en_a, addr_a, rd_valid_a, done_a, busy_a} !== 14'd0) begin
        $display("FAIL midrst_idle c=%0d got %h want 0", c,
                 {gnt_a, rd_en_a, addr_a, rd_valid_a, done_a, busy_a});
        errs++;
      end
    end
    base1 = 6'd40; len1 = 7'd2; req = 2'b10;
    run_burst(1, 1'b0, 1'b0);
    base0 = 6'd3; len0 = 7'd1; base1 = 6'd50; len1 = 7'd1; req = 2'b11;
    run_burst(0, 1'b1, 1'b0);
    run_burst(1, 1'b0, 1'b0);
  endtask

  task automatic test_lat3();
    sel = 1'b1;
    @(negedge clk);
    base0 = 6'd7; len0 = 7'd2; req = 2'b01;
    run_burst(0, 1'b0, 1'b0);
    base1 = 6'd61; len1 = 7'd5; req = 2'b10;
    run_burst(1, 1'b0, 1'b0);
    len0 = 7'd0; req = 2'b01;
    run_burst(0, 1'b0, 1'b0);
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; sel = 1'b0;
    base0 = '0; base1 = '0; len0 = '0; len1 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_zlen();
    test_stable_inputs();
    test_mid_reset();
    test_lat3();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
